// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop line synchronizer with per-tick history; UART_RX_MAJORITY_VOTE_EN
// turns the bit decision into a 2-of-3 vote over three consecutive ticks.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic baud_tick,
    input  logic rx_in,
    output logic rxs,
    output logic prev,
    output logic bit_val
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b11;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= {sync_reg[0], rx_in};
            if (baud_tick)
                prev_reg <= sync_reg[1];
        end
    end

    assign rxs  = sync_reg[1];
    assign prev = prev_reg;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic prev2_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            prev2_reg <= 1'b1;
        else if (baud_tick)
            prev2_reg <= prev_reg;
    end

    // Samples at target-1 (prev2), target (prev) and target+1 (rxs).
    assign bit_val = (rxs & prev_reg) | (rxs & prev2_reg) | (prev_reg & prev2_reg);
`else
    assign bit_val = rxs;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start check, DATA_W data bits,
// optional parity, 1-2 stop bits, held output word with valid/ready.
// Optional majority voting via UART_RX_MAJORITY_VOTE_EN (see uart_rx_sync).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
);

    localparam int SW = clog2w(OVERSAMPLE);
    localparam int BW = clog2w(DATA_W);
`ifdef UART_RX_MAJORITY_VOTE_EN
    // The vote needs the tick after the nominal sample point.
    localparam logic [SW-1:0] START_TGT = SW'(OVERSAMPLE / 2);
`else
    localparam logic [SW-1:0] START_TGT = SW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [SW-1:0] BIT_TGT   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY_MODE == PARITY_ODD);

    logic rxs;
    logic prev;
    logic bit_val;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_in     (rx_in),
        .rxs       (rxs),
        .prev      (prev),
        .bit_val   (bit_val)
    );

    rx_state_t         state_reg;
    logic [SW-1:0]     s_cnt_reg;
    logic [BW-1:0]     b_idx_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_acc_reg;
    logic              frm_acc_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_valid_reg;
    logic              parity_err_reg;
    logic              frame_err_reg;
    logic              overrun_reg;
    logic              stop_err;

    // Frame error including the stop bit being sampled this tick.
    assign stop_err = frm_acc_reg | ~bit_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            s_cnt_reg      <= '0;
            b_idx_reg      <= '0;
            shift_reg      <= '0;
            par_acc_reg    <= 1'b0;
            frm_acc_reg    <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (rx_valid_reg && rx_ready)
                rx_valid_reg <= 1'b0;

            if (baud_tick) begin
                case (state_reg)
                    IDLE: begin
                        // Only a high-to-low edge starts a frame.
                        if (prev && !rxs) begin
                            state_reg <= START;
                            s_cnt_reg <= '0;
                        end
                    end
                    START: begin
                        if (s_cnt_reg == START_TGT) begin
                            s_cnt_reg <= '0;
                            if (bit_val) begin
                                state_reg <= IDLE;
                            end else begin
                                state_reg   <= DATA;
                                b_idx_reg   <= '0;
                                par_acc_reg <= 1'b0;
                                frm_acc_reg <= 1'b0;
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
                    DATA: begin
                        if (s_cnt_reg == BIT_TGT) begin
                            s_cnt_reg <= '0;
                            shift_reg <= {bit_val, shift_reg[DATA_W-1:1]};
                            if (b_idx_reg == LAST_DATA) begin
                                b_idx_reg <= '0;
                                state_reg <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                            end else begin
                                b_idx_reg <= b_idx_reg + BW'(1);
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
                    PARITY: begin
                        if (s_cnt_reg == BIT_TGT) begin
                            s_cnt_reg   <= '0;
                            par_acc_reg <= (^shift_reg) ^ bit_val ^ ODD_SEL;
                            state_reg   <= STOP;
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
                    STOP: begin
                        if (s_cnt_reg == BIT_TGT) begin
                            s_cnt_reg <= '0;
                            if (b_idx_reg == LAST_STOP) begin
                                b_idx_reg <= '0;
                                state_reg <= IDLE;
                                // A pending accept frees the register this same clk.
                                if (!rx_valid_reg || rx_ready) begin
                                    rx_data_reg    <= shift_reg;
                                    parity_err_reg <= par_acc_reg;
                                    frame_err_reg  <= stop_err;
                                    rx_valid_reg   <= 1'b1;
                                end else begin
                                    overrun_reg <= 1'b1;
                                end
                            end else begin
                                frm_acc_reg <= stop_err;
                                b_idx_reg   <= b_idx_reg + BW'(1);
                            end
                        end else begin
                            s_cnt_reg <= s_cnt_reg + SW'(1);
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign rx_data     = rx_data_reg;
    assign rx_valid    = rx_valid_reg;
    assign parity_err  = (PARITY_MODE == PARITY_NONE) ? 1'b0 : parity_err_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_reg;
    assign busy        = (state_reg != IDLE);

endmodule
